// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared Gray-code helpers and depth check for the async FIFO
//
// Purpose: helpers shared by the read-side and write-side pointer managers.
//   bin2gray / gray2bin work on any pointer width up to 32 bits: callers
//   zero-extend the pointer in and truncate the result back out. Zero upper
//   bits are neutral for both conversions.
//   depth_ok() returns 1 for FIFO depths that are a power of two and at least 4.
package async_fifo_pkg;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above its position.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit depth_ok(input int unsigned depth);
    return is_pow2(depth) && (depth >= 4);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser with synchronous active-high reset
//
// Ports:
//   clk_i  destination-domain clock
//   rst_i  synchronous active-high reset, clears both stages
//   d_i    asynchronous input bus (must be Gray-coded or otherwise single-bit-change)
//   q_o    synchronised output (second stage)
module sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1;

  // Nothing sits between the stages so the first flop gets a full cycle to settle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1  <= '0;
      q_o <= '0;
    end else begin
      s1  <= d_i;
      q_o <= s1;
    end
  end

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// rtl/async_fifo_rd_ctrl.sv - read-domain pointer, flags and data register of the async FIFO
//
// Purpose: owns the read pointer, brings the write-side Gray pointer into
//   rd_clk_i, produces empty / almost-empty / fill level, drives the RAM read
//   port and registers the returned word with a one-cycle valid strobe.
// Ports:
//   rd_clk_i        read-domain clock
//   rst_i           synchronous active-high reset
//   rd_en_i         consumer read request (ignored while empty_o)
//   wr_gray_i       write pointer, Gray-coded, asynchronous
//   rd_mem_data_i   RAM read data, valid the cycle after rd_mem_en_o
//   rd_mem_en_o     RAM read enable (combinational accept)
//   rd_ptr_o        RAM read address
//   rd_gray_o       registered Gray read pointer for the write domain
//   rd_data_o       registered read word, held between reads
//   rd_valid_o      one-cycle strobe qualifying rd_data_o
//   empty_o         registered empty flag
//   almost_empty_o  registered level <= AEMPTY_TH
//   rd_level_o      entries available, read-domain view
module async_fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR       = $clog2(FIFO_DEPTH),
  parameter int unsigned AEMPTY_TH  = 2
) (
  input  logic                  rd_clk_i,
  input  logic                  rst_i,
  input  logic                  rd_en_i,
  input  logic [ADDR:0]         wr_gray_i,
  input  logic [FIFO_WIDTH-1:0] rd_mem_data_i,
  output logic                  rd_mem_en_o,
  output logic [ADDR-1:0]       rd_ptr_o,
  output logic [ADDR:0]         rd_gray_o,
  output logic [FIFO_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  empty_o,
  output logic                  almost_empty_o,
  output logic [ADDR:0]         rd_level_o
);

  if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
    $error("async_fifo_rd_ctrl: FIFO_DEPTH must be a power of two and at least 4");
  end

  logic          accept;
  logic [ADDR:0] rd_addr;
  logic [ADDR:0] rd_addr_next;
  logic [ADDR:0] rd_gray_next;
  logic [ADDR:0] wr_gray_s2;
  logic [ADDR:0] wr_bin_s2;
  logic [ADDR:0] level_next;
  logic          rd_vld_pipe;

  sync_2ff #(
    .WIDTH(ADDR + 1)
  ) u_wr_gray_sync (
    .clk_i(rd_clk_i),
    .rst_i(rst_i),
    .d_i  (wr_gray_i),
    .q_o  (wr_gray_s2)
  );

  assign accept       = rd_en_i && !empty_o;
  assign rd_mem_en_o  = accept;
  assign rd_ptr_o     = rd_addr[ADDR-1:0];
  // The extra MSB is the wrap phase; it lets full and empty be told apart.
  assign rd_addr_next = rd_addr + {{ADDR{1'b0}}, accept};
  assign rd_gray_next = (ADDR + 1)'(bin2gray(32'(rd_addr_next)));
  assign wr_bin_s2    = (ADDR + 1)'(gray2bin(32'(wr_gray_s2)));
  // Modulo subtraction over ADDR+1 bits yields 0..FIFO_DEPTH.
  assign level_next   = wr_bin_s2 - rd_addr_next;

  always_ff @(posedge rd_clk_i) begin
    if (rst_i) begin
      rd_addr        <= '0;
      rd_gray_o      <= '0;
      empty_o        <= 1'b1;
      almost_empty_o <= 1'b1;
      rd_level_o     <= '0;
      rd_vld_pipe    <= 1'b0;
      rd_valid_o     <= 1'b0;
      rd_data_o      <= '0;
    end else begin
      rd_addr        <= rd_addr_next;
      rd_gray_o      <= rd_gray_next;
      // Compared against the post-read pointer, so empty rises on the same
      // edge that takes the last word; the stale synced write pointer can only
      // keep it high longer, never drop it early.
      empty_o        <= (rd_gray_next == wr_gray_s2);
      rd_level_o     <= level_next;
      almost_empty_o <= (32'(level_next) <= AEMPTY_TH);
      // RAM returns data the cycle after the accept; capture it then.
      rd_vld_pipe    <= accept;
      rd_valid_o     <= rd_vld_pipe;
      if (rd_vld_pipe) begin
        rd_data_o <= rd_mem_data_i;
      end
    end
  end

endmodule
